// File: rtl/dct_vec_rot_if.sv
// Streaming bus between the FFT source port and the DCT post-rotation stage.
// slave: the rotation block (consumes sink_*, produces source_*).
// master: whatever drives the sink side and observes the source side.
interface dct_vec_rot_if #(
  parameter int wDataIn  = 18,
  parameter int wDataOut = 18
);
  logic                       sink_valid;
  logic                       sink_sop;
  logic                       sink_eop;
  logic signed [wDataIn-1:0]  sink_real;
  logic signed [wDataIn-1:0]  sink_imag;
  logic [11:0]                fftpts_in;
  logic                       source_valid;
  logic                       source_sop;
  logic                       source_eop;
  logic                       source_error;
  logic signed [wDataOut-1:0] source_data;

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, fftpts_in,
    output source_valid, source_sop, source_eop, source_error, source_data
  );

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, fftpts_in,
    input  source_valid, source_sop, source_eop, source_error, source_data
  );
endinterface

// File: rtl/dct_vec_rot.sv
// Forward-DCT post-rotation: D(k) = Re(X(k)*exp(-j*pi*k/2N)) * w'(k).
// Four-stage streaming pipeline: frame tracking/address generation, coefficient
// ROM read, two real multiplies, then add/round/saturate into the output port.
module dct_vec_rot #(
  parameter int wDataIn  = 18,
  parameter int wDataOut = 18,
  parameter int wCoeff   = 18
) (
  input  logic         clk,
  input  logic         rst_sync,
  dct_vec_rot_if.slave bus
);

  localparam int  PROD_W = wDataIn + wCoeff;
  localparam int  SUM_W  = PROD_W + 1;
  localparam real PI     = 3.14159265358979323846;

  localparam logic signed [SUM_W-1:0]    RND_HALF = SUM_W'(32768);
  localparam logic signed [SUM_W-1:0]    SAT_MAX  = SUM_W'((1 << (wDataOut - 1)) - 1);
  localparam logic signed [SUM_W-1:0]    SAT_MIN  = SUM_W'(-(1 << (wDataOut - 1)));
  localparam logic signed [wDataOut-1:0] OUT_MAX  = {1'b0, {(wDataOut-1){1'b1}}};
  localparam logic signed [wDataOut-1:0] OUT_MIN  = {1'b1, {(wDataOut-1){1'b0}}};

  // Quarter-wave coefficient tables; entry 0 of cos carries the k=0 weight 1/sqrt(2).
  logic signed [wCoeff-1:0] cos_rom [2048];
  logic signed [wCoeff-1:0] sin_rom [2048];

  for (genvar a = 0; a < 2048; a++) begin : g_rom
    localparam real ANG   = PI * a / 4096.0;
    localparam int  COS_V = (a == 0) ? 46341 : $rtoi(65536.0 * $cos(ANG) + 0.5);
    localparam int  SIN_V = (a == 0) ? 0     : $rtoi(65536.0 * $sin(ANG) + 0.5);
    assign cos_rom[a] = wCoeff'(COS_V);
    assign sin_rom[a] = wCoeff'(SIN_V);
  end

  // Returns {step, N-1}; unsupported sizes fall back to N=2048.
  function automatic logic [21:0] decode_size(input logic [11:0] n);
    case (n)
      12'd32:   decode_size = {11'd64, 11'd31};
      12'd64:   decode_size = {11'd32, 11'd63};
      12'd128:  decode_size = {11'd16, 11'd127};
      12'd256:  decode_size = {11'd8,  11'd255};
      12'd512:  decode_size = {11'd4,  11'd511};
      12'd1024: decode_size = {11'd2,  11'd1023};
      default:  decode_size = {11'd1,  11'd2047};
    endcase
  endfunction

  // Round-half-up of a Q16 value down to an integer.
  function automatic logic signed [SUM_W-1:0] round_q16(input logic signed [SUM_W-1:0] s);
    round_q16 = (s + RND_HALF) >>> 16;
  endfunction

  // Clamp to the signed output range instead of wrapping.
  function automatic logic signed [wDataOut-1:0] sat_out(input logic signed [SUM_W-1:0] s);
    if (s > SAT_MAX)      sat_out = OUT_MAX;
    else if (s < SAT_MIN) sat_out = OUT_MIN;
    else                  sat_out = $signed(s[wDataOut-1:0]);
  endfunction

  // Frame tracking state
  logic        frame_open_q, frame_open_d;
  logic [10:0] addr_q, addr_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] step_q, step_d;
  logic [10:0] nlast_q, nlast_d;
  logic        accept, fwd_eop, fwd_err, last_hit;

  // Pipeline registers
  logic                      vld_p0, vld_p1, vld_p2;
  logic                      sop_p0, sop_p1, sop_p2;
  logic                      eop_p0, eop_p1, eop_p2;
  logic                      err_p0, err_p1, err_p2;
  logic [10:0]               addr_p0;
  logic signed [wDataIn-1:0] xr_p0, xi_p0, xr_p1, xi_p1;
  logic signed [wCoeff-1:0]  cos_p1, sin_p1;
  logic signed [PROD_W-1:0]  mr_p2, mi_p2;
  logic signed [SUM_W-1:0]   sum_p2;

  // Output registers
  logic                       src_valid_q, src_sop_q, src_eop_q, src_err_q;
  logic signed [wDataOut-1:0] src_data_q;

  // Accept/drop decision, address stepping and framing-error detection for the incoming sample.
  always_comb begin
    accept       = 1'b0;
    fwd_err      = 1'b0;
    fwd_eop      = 1'b0;
    last_hit     = 1'b0;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    step_d       = step_q;
    nlast_d      = nlast_q;
    frame_open_d = frame_open_q;
    if (bus.sink_valid) begin
      if (bus.sink_sop) begin
        // A sop always restarts cleanly; it is only an error if the previous frame never closed.
        accept            = 1'b1;
        fwd_err           = frame_open_q;
        addr_d            = '0;
        cnt_d             = '0;
        {step_d, nlast_d} = decode_size(bus.fftpts_in);
      end else if (frame_open_q) begin
        accept = 1'b1;
        addr_d = addr_q + step_q;
        cnt_d  = cnt_q + 11'd1;
      end
    end
    if (accept) begin
      // Early eop and missing eop are both errors; a missing eop is forced so the frame still closes.
      last_hit     = (cnt_d == nlast_d);
      fwd_err      = fwd_err | (bus.sink_eop != last_hit);
      fwd_eop      = bus.sink_eop | last_hit;
      frame_open_d = ~fwd_eop;
    end
  end

  // Control state and valid pipeline, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      frame_open_q <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      step_q       <= 11'd1;
      nlast_q      <= 11'd2047;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
    end else begin
      frame_open_q <= frame_open_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      nlast_q      <= nlast_d;
      vld_p0       <= accept;
      vld_p1       <= vld_p0;
      vld_p2       <= vld_p1;
    end
  end

  // S0: capture sample, coefficient address and the frame flags.
  always_ff @(posedge clk) begin
    xr_p0   <= bus.sink_real;
    xi_p0   <= bus.sink_imag;
    addr_p0 <= addr_d;
    sop_p0  <= bus.sink_sop;
    eop_p0  <= fwd_eop;
    err_p0  <= fwd_err;
  end

  // S1: registered ROM lookup, sample delayed to line up with the coefficients.
  always_ff @(posedge clk) begin
    cos_p1 <= cos_rom[addr_p0];
    sin_p1 <= sin_rom[addr_p0];
    xr_p1  <= xr_p0;
    xi_p1  <= xi_p0;
    sop_p1 <= sop_p0;
    eop_p1 <= eop_p0;
    err_p1 <= err_p0;
  end

  // S2: the two full-precision products of the real-part extraction.
  always_ff @(posedge clk) begin
    mr_p2  <= xr_p1 * cos_p1;
    mi_p2  <= xi_p1 * sin_p1;
    sop_p2 <= sop_p1;
    eop_p2 <= eop_p1;
    err_p2 <= err_p1;
  end

  assign sum_p2 = SUM_W'(mr_p2) + SUM_W'(mi_p2);

  // S3: sum, round, saturate into the output registers; flags are masked by valid.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      src_err_q   <= 1'b0;
      src_data_q  <= '0;
    end else begin
      src_valid_q <= vld_p2;
      src_sop_q   <= vld_p2 & sop_p2;
      src_eop_q   <= vld_p2 & eop_p2;
      src_err_q   <= vld_p2 & err_p2;
      if (vld_p2) src_data_q <= sat_out(round_q16(sum_p2));
    end
  end

  assign bus.source_valid = src_valid_q;
  assign bus.source_sop   = src_sop_q;
  assign bus.source_eop   = src_eop_q;
  assign bus.source_error = src_err_q;
  assign bus.source_data  = src_data_q;

endmodule

// File: tb/tb_dct_vec_rot.sv
// Directed bench for dct_vec_rot: each task drives one scenario and checks the
// captured output stream (data, sop/eop/error flags, arrival cycle) inline.
module tb_dct_vec_rot;

  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_sync;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  dct_vec_rot_if #(.wDataIn(18), .wDataOut(18)) bus ();

  dct_vec_rot #(.wDataIn(18), .wDataOut(18), .wCoeff(18)) dut (
    .clk      (clk),
    .rst_sync (rst_sync),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Captured outputs and expected outputs: data, {sop,eop,err}, cycle seen.
  int         o_d[$], o_c[$], e_d[$], e_c[$];
  logic [2:0] o_f[$], e_f[$];

  always @(negedge clk) begin
    if (bus.source_valid === 1'b1) begin
      o_d.push_back(int'(bus.source_data));
      o_f.push_back({bus.source_sop, bus.source_eop, bus.source_error});
      o_c.push_back(cyc);
    end
  end

  function automatic int coef(input bit is_sin, input int a);
    if (a == 0) return is_sin ? 0 : 46341;
    return $rtoi(65536.0 * (is_sin ? $sin(PI * a / 4096.0) : $cos(PI * a / 4096.0)) + 0.5);
  endfunction

  function automatic int gold(input int xr, input int xi, input int a);
    longint p, r;
    p = longint'(xr) * coef(1'b0, a) + longint'(xi) * coef(1'b1, a);
    r = (p + 64'sd32768) >>> 16;
    if (r > 131071)  return 131071;
    if (r < -131072) return -131072;
    return int'(r);
  endfunction

  task automatic clear_q();
    o_d.delete(); o_c.delete(); o_f.delete();
    e_d.delete(); e_c.delete(); e_f.delete();
  endtask

  // Drive one cycle; when expo is set, record the output this sample must produce.
  task automatic send(input bit v, input bit s, input bit e, input int xr, input int xi,
                      input bit expo, input int a, input logic [2:0] ef);
    @(negedge clk);
    bus.sink_valid = v;
    bus.sink_sop   = s;
    bus.sink_eop   = e;
    bus.sink_real  = 18'(xr);
    bus.sink_imag  = 18'(xi);
    if (expo) begin
      e_d.push_back(gold(xr, xi, a & 2047));
      e_f.push_back(ef);
      e_c.push_back(cyc + 4);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 3'b000);
  endtask

  task automatic test_reset();
    rst_sync = 1'b1;
    repeat (2) @(negedge clk);
    nvec += 5;
    if (bus.source_valid !== 1'b0) begin nerr++; $display("FAIL reset valid: got %b want 0", bus.source_valid); end
    if (bus.source_sop   !== 1'b0) begin nerr++; $display("FAIL reset sop: got %b want 0", bus.source_sop); end
    if (bus.source_eop   !== 1'b0) begin nerr++; $display("FAIL reset eop: got %b want 0", bus.source_eop); end
    if (bus.source_error !== 1'b0) begin nerr++; $display("FAIL reset error: got %b want 0", bus.source_error); end
    if (bus.source_data  !== 18'sd0) begin nerr++; $display("FAIL reset data: got %0d want 0", bus.source_data); end
    rst_sync = 1'b0;
    idle(2);
  endtask

  task automatic test_n32();
    clear_q();
    bus.fftpts_in = 12'd32;
    for (int k = 0; k < 32; k++)
      send(1'b1, k == 0, k == 31, 1000, 0, 1'b1, k * 64, {k == 0, k == 31, 1'b0});
    idle(6);
    nvec += 3;
    if (o_d.size() < 1 || o_d[0] !== 707) begin nerr++; $display("FAIL n32 D0: got %0d want 707", o_d.size() > 0 ? o_d[0] : 0); end
    if (o_d.size() < 2 || o_d[1] !== 999) begin nerr++; $display("FAIL n32 D1: got %0d want 999", o_d.size() > 1 ? o_d[1] : 0); end
    if (o_d.size() !== e_d.size()) begin nerr++; $display("FAIL n32 count: got %0d want %0d", o_d.size(), e_d.size()); end
    for (int i = 0; i < e_d.size() && i < o_d.size(); i++) begin
      nvec++;
      if (o_d[i] !== e_d[i] || o_f[i] !== e_f[i] || o_c[i] !== e_c[i]) begin
        nerr++;
        $display("FAIL n32 out %0d: got d=%0d f=%b c=%0d want d=%0d f=%b c=%0d", i, o_d[i], o_f[i], o_c[i], e_d[i], e_f[i], e_c[i]);
      end
    end
  endtask

  task automatic test_n2048();
    int xr, xi;
    clear_q();
    bus.fftpts_in = 12'd2048;
    for (int k = 0; k < 2048; k++) begin
      xr = (k == 1024) ? 0     : ((k * 73) % 4001) - 2000;
      xi = (k == 1024) ? 65536 : ((k * 151) % 3001) - 1500;
      send(1'b1, k == 0, k == 2047, xr, xi, 1'b1, k, {k == 0, k == 2047, 1'b0});
    end
    idle(6);
    nvec += 2;
    if (o_d.size() < 1025 || o_d[1024] !== 46341) begin nerr++; $display("FAIL n2048 k1024: got %0d want 46341", o_d.size() > 1024 ? o_d[1024] : 0); end
    if (o_d.size() !== e_d.size()) begin nerr++; $display("FAIL n2048 count: got %0d want %0d", o_d.size(), e_d.size()); end
    for (int i = 0; i < e_d.size() && i < o_d.size(); i++) begin
      nvec++;
      if (o_d[i] !== e_d[i] || o_f[i] !== e_f[i] || o_c[i] !== e_c[i]) begin
        nerr++;
        $display("FAIL n2048 out %0d: got d=%0d f=%b c=%0d want d=%0d f=%b c=%0d", i, o_d[i], o_f[i], o_c[i], e_d[i], e_f[i], e_c[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int x;
    clear_q();
    bus.fftpts_in = 12'd3000;  // unsupported size: must behave as N=2048
    for (int k = 0; k < 2048; k++) begin
      x = (k == 1024) ? 131071 : (k == 1025) ? -131072 : 0;
      send(1'b1, k == 0, k == 2047, x, x, 1'b1, k, {k == 0, k == 2047, 1'b0});
    end
    idle(6);
    nvec += 3;
    if (o_d.size() < 1025 || o_d[1024] !== 131071) begin nerr++; $display("FAIL sat pos: got %0d want 131071", o_d.size() > 1024 ? o_d[1024] : 0); end
    if (o_d.size() < 1026 || o_d[1025] !== -131072) begin nerr++; $display("FAIL sat neg: got %0d want -131072", o_d.size() > 1025 ? o_d[1025] : 0); end
    if (o_d.size() !== e_d.size()) begin nerr++; $display("FAIL sat count: got %0d want %0d", o_d.size(), e_d.size()); end
    for (int i = 0; i < e_d.size() && i < o_d.size(); i++) begin
      nvec++;
      if (o_d[i] !== e_d[i] || o_f[i] !== e_f[i] || o_c[i] !== e_c[i]) begin
        nerr++;
        $display("FAIL sat out %0d: got d=%0d f=%b c=%0d want d=%0d f=%b c=%0d", i, o_d[i], o_f[i], o_c[i], e_d[i], e_f[i], e_c[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    bus.fftpts_in = 12'd64;
    for (int k = 0; k < 64; k++) begin
      if (k == 20) idle(3);
      send(1'b1, k == 0, k == 63, 20000, -15000, 1'b1, k * 32, {k == 0, k == 63, 1'b0});
    end
    bus.fftpts_in = 12'd1024;
    for (int k = 0; k < 1024; k++) begin
      if (k == 500) idle(3);
      send(1'b1, k == 0, k == 1023, ((k * 37) % 2000) - 1000, 5000, 1'b1, k * 2, {k == 0, k == 1023, 1'b0});
    end
    idle(6);
    nvec++;
    if (o_d.size() !== e_d.size()) begin nerr++; $display("FAIL b2b count: got %0d want %0d", o_d.size(), e_d.size()); end
    for (int i = 0; i < e_d.size() && i < o_d.size(); i++) begin
      nvec++;
      if (o_d[i] !== e_d[i] || o_f[i] !== e_f[i] || o_c[i] !== e_c[i]) begin
        nerr++;
        $display("FAIL b2b out %0d: got d=%0d f=%b c=%0d want d=%0d f=%b c=%0d", i, o_d[i], o_f[i], o_c[i], e_d[i], e_f[i], e_c[i]);
      end
    end
  endtask

  task automatic test_framing();
    clear_q();
    bus.fftpts_in = 12'd128;
    // Early eop at sample 99.
    for (int k = 0; k < 100; k++)
      send(1'b1, k == 0, k == 99, 1000, 300, 1'b1, k * 16, {k == 0, k == 99, k == 99});
    // Missing eop: forced at sample 127.
    for (int k = 0; k < 128; k++)
      send(1'b1, k == 0, 1'b0, 1000, 300, 1'b1, k * 16, {k == 0, k == 127, k == 127});
    // Stray samples with no open frame.
    for (int k = 0; k < 5; k++)
      send(1'b1, 1'b0, k == 4, 777, 777, 1'b0, 0, 3'b000);
    // Frame interrupted by a new sop, which restarts at address 0 with error.
    for (int k = 0; k < 10; k++)
      send(1'b1, k == 0, 1'b0, 1000, 300, 1'b1, k * 16, {k == 0, 1'b0, 1'b0});
    for (int k = 0; k < 128; k++)
      send(1'b1, k == 0, k == 127, 1000, 300, 1'b1, k * 16, {k == 0, k == 127, k == 0});
    idle(6);
    nvec += 2;
    if (o_f.size() < 100 || o_f[99] !== 3'b011) begin nerr++; $display("FAIL frame early eop flags: got %b want 011", o_f.size() > 99 ? o_f[99] : 3'b000); end
    if (o_d.size() !== e_d.size()) begin nerr++; $display("FAIL frame count: got %0d want %0d", o_d.size(), e_d.size()); end
    for (int i = 0; i < e_d.size() && i < o_d.size(); i++) begin
      nvec++;
      if (o_d[i] !== e_d[i] || o_f[i] !== e_f[i] || o_c[i] !== e_c[i]) begin
        nerr++;
        $display("FAIL frame out %0d: got d=%0d f=%b c=%0d want d=%0d f=%b c=%0d", i, o_d[i], o_f[i], o_c[i], e_d[i], e_f[i], e_c[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_q();
    bus.fftpts_in = 12'd256;
    // Samples 47..50 are still in flight when reset hits and must vanish.
    for (int k = 0; k < 51; k++)
      send(1'b1, k == 0, 1'b0, -3000, 2500, k <= 46, k * 8, {k == 0, 1'b0, 1'b0});
    rst_sync = 1'b1;
    @(negedge clk);
    rst_sync       = 1'b0;
    bus.sink_valid = 1'b0;
    nvec += 5;
    if (bus.source_valid !== 1'b0) begin nerr++; $display("FAIL midrst valid: got %b want 0", bus.source_valid); end
    if (bus.source_sop   !== 1'b0) begin nerr++; $display("FAIL midrst sop: got %b want 0", bus.source_sop); end
    if (bus.source_eop   !== 1'b0) begin nerr++; $display("FAIL midrst eop: got %b want 0", bus.source_eop); end
    if (bus.source_error !== 1'b0) begin nerr++; $display("FAIL midrst error: got %b want 0", bus.source_error); end
    if (bus.source_data  !== 18'sd0) begin nerr++; $display("FAIL midrst data: got %0d want 0", bus.source_data); end
    // Rest of the aborted frame: no frame is open, so nothing comes out.
    for (int k = 51; k < 61; k++)
      send(1'b1, 1'b0, 1'b0, -3000, 2500, 1'b0, 0, 3'b000);
    for (int k = 0; k < 256; k++)
      send(1'b1, k == 0, k == 255, 4000, -2000, 1'b1, k * 8, {k == 0, k == 255, 1'b0});
    idle(6);
    nvec++;
    if (o_d.size() !== e_d.size()) begin nerr++; $display("FAIL midrst count: got %0d want %0d", o_d.size(), e_d.size()); end
    for (int i = 0; i < e_d.size() && i < o_d.size(); i++) begin
      nvec++;
      if (o_d[i] !== e_d[i] || o_f[i] !== e_f[i] || o_c[i] !== e_c[i]) begin
        nerr++;
        $display("FAIL midrst out %0d: got d=%0d f=%b c=%0d want d=%0d f=%b c=%0d", i, o_d[i], o_f[i], o_c[i], e_d[i], e_f[i], e_c[i]);
      end
    end
  endtask

  initial begin
    rst_sync       = 1'b1;
    bus.sink_valid = 1'b0;
    bus.sink_sop   = 1'b0;
    bus.sink_eop   = 1'b0;
    bus.sink_real  = '0;
    bus.sink_imag  = '0;
    bus.fftpts_in  = 12'd0;
    test_reset();
    test_n32();
    test_n2048();
    test_saturation();
    test_back_to_back();
    test_framing();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
